// File: rtl/sim_run_monitor.sv
// End-of-test monitor: detects a self-loop opcode-fetch trap, optional gpio result code, or cycle-budget timeout.
// Optional gpio pass/fail detection is compiled in when TEST_MON_GPIO_EN is defined.
module sim_run_monitor #(
  parameter int unsigned        ADDR_W         = 16,
  parameter int unsigned        GPIO_W         = 8,
  parameter int unsigned        CNT_W          = 32,
  parameter logic [CNT_W-1:0]   TIMEOUT_CYCLES = '0,
  parameter int unsigned        TRAP_REPEAT    = 4,
  parameter logic [ADDR_W-1:0]  PASS_ADDR      = 16'h3469,
  parameter logic [GPIO_W-1:0]  PASS_CODE      = 8'h01,
  parameter logic [GPIO_W-1:0]  FAIL_CODE      = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_sync,
  input  logic [GPIO_W-1:0] gpio_o,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              trap,
  output logic [ADDR_W-1:0] trap_addr,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned REP_W = $clog2(TRAP_REPEAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_pc;
  logic [REP_W-1:0]  rep_cnt;

  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_sat;
  logic [REP_W-1:0]  rep_inc;
  logic              addr_match;
  logic              trap_hit;
  logic              timeout_hit;
  logic              gpio_pass_hit;
  logic              gpio_fail_hit;

  // rep_cnt==0 marks "no fetch seen yet in this run", so the first fetch always reloads last_pc.
  always_comb begin
    cnt_inc     = cycle_count + CNT_W'(1);
    cnt_sat     = (&cycle_count) ? cycle_count : cnt_inc;
    rep_inc     = rep_cnt + REP_W'(1);
    addr_match  = (rep_cnt != '0) && (cpu_addr == last_pc);
    trap_hit    = cpu_sync && addr_match && (rep_inc == REP_W'(TRAP_REPEAT));
    timeout_hit = (TIMEOUT_CYCLES != '0) && (cnt_inc == TIMEOUT_CYCLES);
  end

`ifdef TEST_MON_GPIO_EN
  logic [GPIO_W-1:0] gpio_q;

  always_comb begin
    gpio_pass_hit = (gpio_o != gpio_q) && (gpio_o == PASS_CODE);
    gpio_fail_hit = (gpio_o != gpio_q) && (gpio_o == FAIL_CODE);
  end

  // Loaded on the entry cycle so a code already present at start is not seen as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q <= '0;
    end else if ((state == S_IDLE && enable && !clear) || state == S_RUN) begin
      gpio_q <= gpio_o;
    end
  end
`else
  logic gpio_unused;
  assign gpio_unused   = ^gpio_o;
  assign gpio_pass_hit = 1'b0;
  assign gpio_fail_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= S_IDLE;
      last_pc     <= '0;
      rep_cnt     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      trap        <= 1'b0;
      trap_addr   <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state       <= S_RUN;
            cycle_count <= '0;
            rep_cnt     <= '0;
            last_pc     <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cnt_sat;
          if (cpu_sync) begin
            if (addr_match) begin
              rep_cnt <= rep_inc;
            end else begin
              rep_cnt <= REP_W'(1);
              last_pc <= cpu_addr;
            end
          end
          if (trap_hit) begin
            state     <= S_DONE;
            done      <= 1'b1;
            trap      <= 1'b1;
            trap_addr <= cpu_addr;
            pass      <= (cpu_addr == PASS_ADDR);
            fail      <= (cpu_addr != PASS_ADDR);
          end else if (gpio_pass_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (gpio_fail_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            fail  <= 1'b1;
          end else if (timeout_hit) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            fail    <= 1'b1;
          end
        end
        S_DONE: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_monitor.sv
// Self-checking bench for sim_run_monitor: directed vector table, corner sequences, random run vs. reference model.
module tb_sim_run_monitor;

  localparam int unsigned TREP = 4;
  localparam int unsigned TMO  = 100;

  logic        clk = 1'b0;
  logic        reset, enable, clear, cpu_sync;
  logic [15:0] cpu_addr;
  logic [7:0]  gpio_o;
  logic        done, pass, fail, timeout, trap;
  logic [15:0] trap_addr;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  sim_run_monitor #(
    .ADDR_W(16), .GPIO_W(8), .CNT_W(32),
    .TIMEOUT_CYCLES(32'd100), .TRAP_REPEAT(4),
    .PASS_ADDR(16'h3469), .PASS_CODE(8'h01), .FAIL_CODE(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .cpu_addr(cpu_addr), .cpu_sync(cpu_sync), .gpio_o(gpio_o),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .trap(trap),
    .trap_addr(trap_addr), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference model: run phase, fetch history and run length tracked directly from the rules.
  int          m_st;
  logic [15:0] m_hist[$];
  logic [31:0] m_cyc;
  logic [7:0]  m_gprev;
  logic        m_done, m_pass, m_fail, m_trap, m_to;
  logic [15:0] m_taddr;

  function automatic void model_step(logic r, logic c, logic e, logic s, logic [15:0] a, logic [7:0] g);
    bit tr, gp, gf, to;
    tr = 0; gp = 0; gf = 0; to = 0;
    if (r || c) begin
      m_st = 0; m_hist.delete(); m_cyc = 0; m_taddr = 0;
      m_done = 0; m_pass = 0; m_fail = 0; m_trap = 0; m_to = 0;
    end else if (m_st == 0) begin
      if (e) begin
        m_st = 1; m_cyc = 0; m_hist.delete(); m_gprev = g;
      end
    end else if (m_st == 1) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (s) begin
        m_hist.push_back(a);
        if (m_hist.size() > TREP) void'(m_hist.pop_front());
        if (m_hist.size() == TREP) begin
          tr = 1;
          foreach (m_hist[k]) if (m_hist[k] != a) tr = 0;
        end
      end
`ifdef TEST_MON_GPIO_EN
      gp = (g != m_gprev) && (g == 8'h01);
      gf = (g != m_gprev) && (g == 8'hFF);
      m_gprev = g;
`endif
      to = (m_cyc == TMO);
      if (tr) begin
        m_st = 2; m_done = 1; m_trap = 1; m_taddr = a;
        m_pass = (a == 16'h3469); m_fail = (a != 16'h3469);
      end else if (gp) begin
        m_st = 2; m_done = 1; m_pass = 1;
      end else if (gf) begin
        m_st = 2; m_done = 1; m_fail = 1;
      end else if (to) begin
        m_st = 2; m_done = 1; m_to = 1; m_fail = 1;
      end
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic drive(logic r, logic c, logic e, logic s, logic [15:0] a, logic [7:0] g);
    reset = r; clear = c; enable = e; cpu_sync = s; cpu_addr = a; gpio_o = g;
  endtask

  task automatic step();
    model_step(reset, clear, enable, cpu_sync, cpu_addr, gpio_o);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string tag, logic d, logic p, logic f, logic tr, logic to, logic [15:0] ta, logic [31:0] cc);
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".pass"}, 32'(pass), 32'(p));
    chk({tag, ".fail"}, 32'(fail), 32'(f));
    chk({tag, ".trap"}, 32'(trap), 32'(tr));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    chk({tag, ".trap_addr"}, 32'(trap_addr), 32'(ta));
    chk({tag, ".cycle_count"}, cycle_count, cc);
  endtask

  typedef struct {
    logic rst, clr, en, sync;
    logic [15:0] addr;
    logic [7:0]  gpio;
    logic e_done, e_pass, e_fail, e_trap, e_to;
    logic [15:0] e_taddr;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t vt[$];

  function automatic void mk(logic r, logic c, logic e, logic s, logic [15:0] a,
                             logic d, logic p, logic f, logic tr, logic [15:0] ta, logic [31:0] cc);
    vec_t v;
    v.rst = r; v.clr = c; v.en = e; v.sync = s; v.addr = a; v.gpio = 8'h00;
    v.e_done = d; v.e_pass = p; v.e_fail = f; v.e_trap = tr; v.e_to = 1'b0;
    v.e_taddr = ta; v.e_cyc = cc;
    vt.push_back(v);
  endfunction

  initial begin
    int n;
    bit stable;
    logic [7:0] gpool [4];
    logic [15:0] apool [4];
    gpool[0] = 8'h00; gpool[1] = 8'h01; gpool[2] = 8'hFF; gpool[3] = 8'h5A;
    apool[0] = 16'h3469; apool[1] = 16'h1234; apool[2] = 16'h0400; apool[3] = 16'h0401;

    // Reset held 3 cycles under random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
      step();
      chk_out("reset", 0, 0, 0, 0, 0, 16'h0, 32'd0);
    end

    //  rst clr en sync addr      done pass fail trap taddr     cyc
    mk(1, 0, 1, 1, 16'h3469,   0, 0, 0, 0, 16'h0000, 0);
    mk(0, 0, 0, 1, 16'h3469,   0, 0, 0, 0, 16'h0000, 0);
    mk(0, 0, 1, 0, 16'h0000,   0, 0, 0, 0, 16'h0000, 0);
    mk(0, 0, 0, 1, 16'h0400,   0, 0, 0, 0, 16'h0000, 1);
    mk(0, 0, 0, 1, 16'h0402,   0, 0, 0, 0, 16'h0000, 2);
    mk(0, 0, 0, 1, 16'h3469,   0, 0, 0, 0, 16'h0000, 3);
    mk(0, 0, 0, 1, 16'h3469,   0, 0, 0, 0, 16'h0000, 4);
    mk(0, 0, 0, 1, 16'h3469,   0, 0, 0, 0, 16'h0000, 5);
    mk(0, 0, 0, 1, 16'h3469,   1, 1, 0, 1, 16'h3469, 6);
    mk(0, 0, 1, 1, 16'h1111,   1, 1, 0, 1, 16'h3469, 6);
    mk(0, 1, 0, 0, 16'h0000,   0, 0, 0, 0, 16'h0000, 0);
    mk(0, 0, 1, 0, 16'h0000,   0, 0, 0, 0, 16'h0000, 0);
    mk(0, 0, 0, 1, 16'h1234,   0, 0, 0, 0, 16'h0000, 1);
    mk(0, 0, 0, 0, 16'h5555,   0, 0, 0, 0, 16'h0000, 2);
    mk(0, 0, 0, 1, 16'h1234,   0, 0, 0, 0, 16'h0000, 3);
    mk(0, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 16'h0000, 4);
    mk(0, 0, 0, 1, 16'h1234,   0, 0, 0, 0, 16'h0000, 5);
    mk(0, 0, 0, 1, 16'h1234,   1, 0, 1, 1, 16'h1234, 6);
    mk(0, 1, 1, 0, 16'h0000,   0, 0, 0, 0, 16'h0000, 0);
    mk(0, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 16'h0000, 0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].clr, vt[i].en, vt[i].sync, vt[i].addr, vt[i].gpio);
      step();
      chk_out($sformatf("vec%0d", i), vt[i].e_done, vt[i].e_pass, vt[i].e_fail,
              vt[i].e_trap, vt[i].e_to, vt[i].e_taddr, vt[i].e_cyc);
    end

    // Timeout with distinct fetches
    drive(0, 1, 0, 0, 16'h0, 8'h00); step();
    drive(0, 0, 1, 0, 16'h0, 8'h00); step();
    n = 0;
    for (int i = 0; i < 150; i++) begin
      drive(0, 0, 0, 1, 16'h1000 + 16'(i), 8'h00);
      step();
      n = i + 1;
      if (done) break;
    end
    chk("timeout.latency", 32'(n), 32'(TMO));
    chk_out("timeout", 1, 0, 1, 0, 1, 16'h0, 32'd100);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1'($urandom), 1'($urandom), 16'($urandom), 8'h00);
      step();
      if (!(done && timeout && fail && !pass && !trap && cycle_count == 32'd100)) stable = 0;
    end
    chk("timeout.hold", 32'(stable), 32'd1);

    // Trap on the same cycle the budget expires
    drive(0, 1, 0, 0, 16'h0, 8'h00); step();
    drive(0, 0, 1, 0, 16'h0, 8'h00); step();
    for (int i = 0; i < 96; i++) begin
      drive(0, 0, 0, 1, 16'h1000 + 16'(i), 8'h00); step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 16'h2222, 8'h00); step();
    end
    chk_out("collide", 1, 0, 1, 1, 0, 16'h2222, 32'd100);
    drive(0, 1, 0, 0, 16'h0, 8'h00); step();
    chk_out("collide_clr", 0, 0, 0, 0, 0, 16'h0, 32'd0);
    drive(0, 0, 1, 0, 16'h0, 8'h00); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 16'h3469, 8'h00); step();
    end
    chk_out("rerun", 1, 1, 0, 1, 0, 16'h3469, 32'd4);

    // gpio result codes: 00->01 then 00->FF
    for (int k = 0; k < 2; k++) begin
      logic [7:0] code;
      code = (k == 0) ? 8'h01 : 8'hFF;
      drive(0, 1, 0, 0, 16'h0, 8'h00); step();
      drive(0, 0, 1, 0, 16'h0, 8'h00); step();
      for (int i = 0; i < 3; i++) begin
        drive(0, 0, 0, 1, 16'h5000 + 16'(i), 8'h00); step();
      end
      drive(0, 0, 0, 1, 16'h5003, code); step();
`ifdef TEST_MON_GPIO_EN
      chk_out($sformatf("gpio%0d", k), 1, (k == 0), (k == 1), 0, 0, 16'h0, 32'd4);
`else
      chk($sformatf("gpio%0d.done", k), 32'(done), 32'd0);
      for (int i = 0; i < 3; i++) begin
        drive(0, 0, 0, 1, 16'h5010 + 16'(i), code); step();
      end
      chk($sformatf("gpio%0d.still_run", k), 32'(done), 32'd0);
      chk($sformatf("gpio%0d.cycle_count", k), cycle_count, 32'd7);
`endif
    end

    // Code already present at start is not a change
    drive(0, 1, 0, 0, 16'h0, 8'h01); step();
    drive(0, 0, 1, 0, 16'h0, 8'h01); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 16'h6000 + 16'(i), 8'h01); step();
    end
    chk("gpio_preset.done", 32'(done), 32'd0);
    chk("gpio_preset.cycle_count", cycle_count, 32'd5);

    // Randomized run against the reference model
    drive(1, 0, 0, 0, 16'h0, 8'h00); step();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] g;
      g = ($urandom_range(0, 7) == 0) ? gpool[$urandom_range(0, 3)] : gpio_o;
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom), apool[$urandom_range(0, 3)], g);
      step();
      chk_out("rand", m_done, m_pass, m_fail, m_trap, m_to, m_taddr, m_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
